gtx_align_insert: RTL

Upstream stage of the GTX 8b/10b encoder. Takes a 16-bit/2-K-flag word stream (two bytes per cycle, one SATA dword per two cycles) from the link layer and inserts an ALIGN primitive pair after every ALIGN_PERIOD dwords, as the SATA spec requires. It back-pressures the source during insertion, fills gaps with SYNC, and drives the encoder's `indata`/`inisk` inputs every cycle.

---
 rtl/gtx_sata_prims.sv | 38 +++
 rtl/gtx_align_insert.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/gtx_sata_prims.sv
// SATA primitive words and FSM encoding shared by the ALIGN inserter and the encoder-side checker.
package gtx_sata_prims;

  localparam logic [15:0] ALIGN_W0 = 16'h4ABC;
  localparam logic [1:0]  ALIGN_K0 = 2'b01;
  localparam logic [15:0] ALIGN_W1 = 16'h7B4A;
  localparam logic [1:0]  ALIGN_K1 = 2'b00;
  localparam logic [15:0] SYNC_W0  = 16'h957C;
  localparam logic [1:0]  SYNC_K0  = 2'b01;
  localparam logic [15:0] SYNC_W1  = 16'hB5B5;
  localparam logic [1:0]  SYNC_K1  = 2'b00;

  typedef enum logic {
    ST_PASS  = 1'b0,
    ST_ALIGN = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  isk;
  } prim_t;

  // odd selects the second word of the dword.
  function automatic prim_t align_word(input logic odd);
    prim_t w;
    w.data = odd ? ALIGN_W1 : ALIGN_W0;
    w.isk  = odd ? ALIGN_K1 : ALIGN_K0;
    return w;
  endfunction

  function automatic prim_t sync_word(input logic odd);
    prim_t w;
    w.data = odd ? SYNC_W1 : SYNC_W0;
    w.isk  = odd ? SYNC_K1 : SYNC_K0;
    return w;
  endfunction

endpackage

// File: rtl/gtx_align_insert.sv
// Inserts an ALIGN pair every ALIGN_PERIOD dwords ahead of the GTX 8b/10b encoder, SYNC-filling gaps.
// Build option GTX_ALIGN_INSERT_EN: defined = ALIGN insertion; undefined = registered pass-through.
module gtx_align_insert
  import gtx_sata_prims::*;
#(
  parameter int unsigned ALIGN_PERIOD = 254
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_isk,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        align_only,
  output logic [15:0] out_data,
  output logic [1:0]  out_isk,
  output logic        err_underrun,
  output state_e      dbg_state
);

  // Handshake: a word transfers on a rising clk edge where in_valid & in_ready;
  // in_ready never depends on in_valid, and in_valid may be dropped at any time.

`ifdef GTX_ALIGN_INSERT_EN

  localparam logic [7:0] PERIOD = 8'(ALIGN_PERIOD);

  state_e      state_q, state_d;
  logic [1:0]  sub_q, sub_d;
  logic        phase_q;
  logic        fill_q, fill_d;
  logic [7:0]  dw_cnt_q, dw_cnt_d;
  prim_t       word_d;
  logic        err_d;
  logic        ready_c;

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    fill_d   = 1'b0;
    dw_cnt_d = dw_cnt_q;
    word_d   = sync_word(phase_q);
    err_d    = 1'b0;
    ready_c  = 1'b0;
    case (state_q)
      ST_ALIGN: begin
        word_d = align_word(sub_q[0]);
        sub_d  = sub_q + 2'd1;
        // align_only is only looked at on a pair boundary so a pair is never split.
        if (sub_q == 2'd3 && !align_only) state_d = ST_PASS;
      end
      default: begin
        if (!phase_q) begin
          if (align_only || dw_cnt_q == PERIOD) begin
            // The first ALIGN word goes out this cycle, so the FSM resumes at sub 1.
            state_d  = ST_ALIGN;
            sub_d    = 2'd1;
            dw_cnt_d = 8'd0;
            word_d   = align_word(1'b0);
          end else begin
            ready_c = 1'b1;
            if (in_valid) begin
              word_d.data = in_data;
              word_d.isk  = in_isk;
            end else begin
              fill_d = 1'b1;
            end
          end
        end else begin
          dw_cnt_d = dw_cnt_q + 8'd1;
          if (!fill_q) begin
            ready_c = 1'b1;
            if (in_valid) begin
              word_d.data = in_data;
              word_d.isk  = in_isk;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_ALIGN;
      sub_q        <= 2'd0;
      phase_q      <= 1'b0;
      fill_q       <= 1'b0;
      dw_cnt_q     <= 8'd0;
      out_data     <= ALIGN_W0;
      out_isk      <= ALIGN_K0;
      err_underrun <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      phase_q      <= ~phase_q;
      fill_q       <= fill_d;
      dw_cnt_q     <= dw_cnt_d;
      out_data     <= word_d.data;
      out_isk      <= word_d.isk;
      err_underrun <= err_d;
    end
  end

  assign in_ready  = rst & ready_c;
  assign dbg_state = state_q;

`else

  logic  phase_q;
  prim_t word_d;
  logic  err_d;
  logic  unused_cfg;

  always_comb begin
    word_d = sync_word(phase_q);
    err_d  = 1'b0;
    if (in_valid) begin
      word_d.data = in_data;
      word_d.isk  = in_isk;
    end else begin
      err_d = phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q      <= 1'b0;
      out_data     <= ALIGN_W0;
      out_isk      <= ALIGN_K0;
      err_underrun <= 1'b0;
    end else begin
      phase_q      <= ~phase_q;
      out_data     <= word_d.data;
      out_isk      <= word_d.isk;
      err_underrun <= err_d;
    end
  end

  assign in_ready   = rst;
  assign dbg_state  = ST_PASS;
  assign unused_cfg = align_only ^ (ALIGN_PERIOD == 0);

`endif

endmodule
